// File: rtl/axis_video_pkg.sv
// Shared video stream definitions: default widths, output FIFO geometry and
// the cropper state encoding.
package axis_video_pkg;

    localparam int unsigned DEF_PIXEL_WIDTH  = 8;
    localparam int unsigned DEF_WIDTH_BITS   = 12;
    localparam int unsigned DEF_HEIGHT_BITS  = 12;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned OCC_W      = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACTIVE   = 2'd1,
        DONE     = 2'd2
    } crop_state_e;

endpackage

// File: rtl/axis_fifo2.sv
// Two-entry register FIFO; the head entry is a flop that drives the output
// stream directly, so the output payload and valid come straight from flops.
module axis_fifo2
    import axis_video_pkg::*;
#(
    parameter int unsigned DW = 10
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push_i,
    input  logic [DW-1:0]    push_data_i,
    input  logic             pop_ready_i,
    output logic [DW-1:0]    head_o,
    output logic             valid_o,
    output logic [OCC_W-1:0] occ_o
);

    logic [DW-1:0]    ent0_q, ent0_d;
    logic [DW-1:0]    ent1_q, ent1_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             valid_q, valid_d;
    logic             pop;

    // Entry 0 is always the head; a pop shifts entry 1 forward.
    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        occ_d   = occ_q;
        pop     = pop_ready_i && valid_q;
        case ({push_i, pop})
            2'b10: begin
                if (occ_q == OCC_W'(0)) ent0_d = push_data_i;
                else                    ent1_d = push_data_i;
                occ_d = occ_q + OCC_W'(1);
            end
            2'b01: begin
                ent0_d = ent1_q;
                occ_d  = occ_q - OCC_W'(1);
            end
            2'b11: begin
                if (occ_q == OCC_W'(1)) begin
                    ent0_d = push_data_i;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = push_data_i;
                end
            end
            default: ;
        endcase
        valid_d = (occ_d != OCC_W'(0));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            occ_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            occ_q   <= occ_d;
            valid_q <= valid_d;
        end
    end

    assign head_o  = ent0_q;
    assign valid_o = valid_q;
    assign occ_o   = occ_q;

endmodule

// File: rtl/axis_window_cropper.sv
// Crops a rectangular window out of an AXI4-Stream video frame; the window is
// captured at each start of frame and output goes through a 2-entry FIFO.
module axis_window_cropper
    import axis_video_pkg::*;
#(
    parameter int unsigned C_PIXEL_WIDTH = DEF_PIXEL_WIDTH,
    parameter int unsigned C_WIDTH_BITS  = DEF_WIDTH_BITS,
    parameter int unsigned C_HEIGHT_BITS = DEF_HEIGHT_BITS
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     s_axis_tvalid,
    input  logic [C_PIXEL_WIDTH-1:0] s_axis_tdata,
    input  logic                     s_axis_tuser,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic                     m_axis_tvalid,
    output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
    output logic                     m_axis_tuser,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    input  logic [C_WIDTH_BITS-1:0]  win_left,
    input  logic [C_WIDTH_BITS-1:0]  win_width,
    input  logic [C_HEIGHT_BITS-1:0] win_top,
    input  logic [C_HEIGHT_BITS-1:0] win_height,
    output logic                     o_frame_err
);

    localparam int unsigned XW = C_WIDTH_BITS + 1;
    localparam int unsigned YW = C_HEIGHT_BITS + 1;
    localparam int unsigned DW = C_PIXEL_WIDTH + 2;
    localparam logic [XW-1:0] X_LIMIT = {1'b1, {C_WIDTH_BITS{1'b0}}};
    localparam logic [YW-1:0] Y_LIMIT = {1'b1, {C_HEIGHT_BITS{1'b0}}};

    crop_state_e              state_q, state_d;
    logic [C_WIDTH_BITS-1:0]  col_q, col_d, left_q, left_d, width_q, width_d;
    logic [C_HEIGHT_BITS-1:0] row_q, row_d, top_q, top_d, height_q, height_d;
    logic                     rdy_q, rdy_d, err_q, err_d;

    logic                     accept, push, pop;
    logic [OCC_W-1:0]         occ, occ_next;
    logic [C_WIDTH_BITS-1:0]  pix_col, eff_left, eff_width;
    logic [C_HEIGHT_BITS-1:0] pix_row, eff_top, eff_height;
    logic [XW-1:0]            x_end;
    logic [YW-1:0]            y_end;
    logic                     win_ok, in_win, last_col, last_row, push_ok;
    logic [DW-1:0]            head;

    // Pixel coordinates and the window in force for the beat on the input.
    always_comb begin
        accept     = s_axis_tvalid && rdy_q;
        pix_col    = s_axis_tuser ? '0 : col_q;
        pix_row    = s_axis_tuser ? '0 : row_q;
        eff_left   = s_axis_tuser ? win_left   : left_q;
        eff_width  = s_axis_tuser ? win_width  : width_q;
        eff_top    = s_axis_tuser ? win_top    : top_q;
        eff_height = s_axis_tuser ? win_height : height_q;
        x_end      = XW'(eff_left) + XW'(eff_width);
        y_end      = YW'(eff_top) + YW'(eff_height);
        win_ok     = (eff_width != '0) && (eff_height != '0) &&
                     (x_end <= X_LIMIT) && (y_end <= Y_LIMIT);
        in_win     = (pix_col >= eff_left) && (XW'(pix_col) < x_end) &&
                     (pix_row >= eff_top)  && (YW'(pix_row) < y_end);
        last_col   = (XW'(pix_col) == x_end - XW'(1));
        last_row   = (YW'(pix_row) == y_end - YW'(1));
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        left_d   = left_q;
        width_d  = width_q;
        top_d    = top_q;
        height_d = height_q;
        err_d    = 1'b0;
        push     = 1'b0;
        push_ok  = s_axis_tuser ? win_ok : (state_q == ACTIVE);
        if (accept) begin
            if (s_axis_tlast) begin
                col_d = '0;
                row_d = pix_row + C_HEIGHT_BITS'(1);
            end else begin
                col_d = pix_col + C_WIDTH_BITS'(1);
                row_d = pix_row;
            end
            if (s_axis_tuser) begin
                left_d   = win_left;
                width_d  = win_width;
                top_d    = win_top;
                height_d = win_height;
                // A SOF mid-frame and a bad window share the single error pulse.
                err_d    = (state_q == ACTIVE) || !win_ok;
                state_d  = win_ok ? ACTIVE : WAIT_SOF;
            end
            if (push_ok && in_win) begin
                push = 1'b1;
                if (last_col && last_row) state_d = DONE;
            end
        end
    end

    // Ready is registered from the post-edge occupancy, so it never sees m_axis_tready combinationally.
    always_comb begin
        pop      = m_axis_tvalid && m_axis_tready;
        occ_next = occ + OCC_W'(push) - OCC_W'(pop);
        rdy_d    = (occ_next < OCC_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= WAIT_SOF;
            col_q    <= '0;
            row_q    <= '0;
            left_q   <= '0;
            width_q  <= '0;
            top_q    <= '0;
            height_q <= '0;
            rdy_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            left_q   <= left_d;
            width_q  <= width_d;
            top_q    <= top_d;
            height_q <= height_d;
            rdy_q    <= rdy_d;
            err_q    <= err_d;
        end
    end

    axis_fifo2 #(
        .DW (DW)
    ) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push_i      (push),
        .push_data_i ({s_axis_tdata,
                       (pix_col == eff_left) && (pix_row == eff_top),
                       last_col}),
        .pop_ready_i (m_axis_tready),
        .head_o      (head),
        .valid_o     (m_axis_tvalid),
        .occ_o       (occ)
    );

    assign {m_axis_tdata, m_axis_tuser, m_axis_tlast} = head;
    assign s_axis_tready = rdy_q;
    assign o_frame_err   = err_q;

endmodule

// File: tb/tb_axis_window_cropper.sv
// Directed bench for axis_window_cropper: frames are generated with an
// expected-output scoreboard and a negedge monitor checks every output beat.
module tb_axis_window_cropper;
    import axis_video_pkg::*;

    localparam int unsigned PW = DEF_PIXEL_WIDTH;
    localparam int unsigned WB = DEF_WIDTH_BITS;
    localparam int unsigned HB = DEF_HEIGHT_BITS;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic [PW-1:0] s_axis_tdata = '0;
    logic          s_axis_tuser = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic          m_axis_tvalid;
    logic [PW-1:0] m_axis_tdata;
    logic          m_axis_tuser;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b1;
    logic [WB-1:0] win_left = '0, win_width = '0;
    logic [HB-1:0] win_top = '0, win_height = '0;
    logic          o_frame_err;

    int vectors = 0;
    int miscompares = 0;
    logic [PW+1:0] exp_q[$];
    int  occ_m = 0;
    int  err_pulses = 0;
    int  out_beats = 0;
    bit  was_rst = 1'b1;
    bit  stalled = 1'b0;
    bit  cur_push = 1'b0;
    bit  tog_en = 1'b0;
    logic [PW+1:0] held = '0;

    always #5 clk = ~clk;

    axis_window_cropper dut (
        .clk           (clk),
        .resetn        (resetn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .win_left      (win_left),
        .win_width     (win_width),
        .win_top       (win_top),
        .win_height    (win_height),
        .o_frame_err   (o_frame_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Output monitor and occupancy tracker, sampled half a cycle from the active edge.
    always @(negedge clk) begin
        if (!resetn) begin
            occ_m   = 0;
            was_rst = 1'b1;
            stalled = 1'b0;
        end else begin
            if (was_rst) was_rst = 1'b0;
            else check("s_tready_vs_occupancy", 32'(s_axis_tready), 32'(occ_m < 2));
            if (o_frame_err) err_pulses++;
            if (stalled) begin
                check("stall_valid", 32'(m_axis_tvalid), 32'(1));
                check("stall_payload", 32'({m_axis_tdata, m_axis_tuser, m_axis_tlast}), 32'(held));
            end
            stalled = m_axis_tvalid && !m_axis_tready;
            held    = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
            if (m_axis_tvalid && m_axis_tready) begin
                out_beats++;
                vectors++;
                assert (exp_q.size() != 0) else begin
                    miscompares++;
                    $error("FAIL unexpected_beat observed=%0h expected=none", held);
                end
                if (exp_q.size() != 0) begin
                    vectors--;
                    check("out_beat", 32'(held), 32'(exp_q.pop_front()));
                end
            end
            if (s_axis_tvalid && s_axis_tready && cur_push) occ_m++;
            if (m_axis_tvalid && m_axis_tready) occ_m--;
        end
    end

    task automatic send_beat(input logic [PW-1:0] d, input logic u, input logic l,
                             input bit exp_push, input logic [PW+1:0] exp_pl);
        int n = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        cur_push      = exp_push;
        if (exp_push) exp_q.push_back(exp_pl);
        @(negedge clk);
        while (!s_axis_tready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!s_axis_tready) begin
            vectors++;
            miscompares++;
            $error("FAIL s_tready_timeout observed=0 expected=1");
            print_summary();
            $fatal(1, "input handshake never completed");
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        cur_push      = 1'b0;
    endtask

    // Drives one fw x fh frame; nbeats >= 0 truncates it after that many beats.
    task automatic send_frame(input int fw, input int fh, input int l, input int t,
                              input int ww, input int wh, input bit ok,
                              input int nbeats, input bit scramble, input int seed);
        int k = 0;
        bit in;
        logic [PW-1:0] d;
        win_left   = WB'(l);
        win_width  = WB'(ww);
        win_top    = HB'(t);
        win_height = HB'(wh);
        for (int r = 0; r < fh; r++) begin
            for (int c = 0; c < fw; c++) begin
                if (nbeats >= 0 && k >= nbeats) return;
                in = ok && (c >= l) && (c < l + ww) && (r >= t) && (r < t + wh);
                d  = PW'(seed + r * 16 + c);
                send_beat(d, (r == 0 && c == 0), (c == fw - 1), in,
                          {d, (c == l && r == t), (c == l + ww - 1)});
                if (scramble && k == 0) begin
                    win_left   = WB'($urandom);
                    win_width  = WB'($urandom);
                    win_top    = HB'($urandom);
                    win_height = HB'($urandom);
                end
                k++;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic print_summary();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    endtask

    initial begin
        int b0, e0;
        #12;
        check("rst_m_tvalid", 32'(m_axis_tvalid), 32'(0));
        check("rst_m_tdata",  32'(m_axis_tdata),  32'(0));
        check("rst_m_tuser",  32'(m_axis_tuser),  32'(0));
        check("rst_m_tlast",  32'(m_axis_tlast),  32'(0));
        check("rst_frame_err", 32'(o_frame_err),  32'(0));
        check("rst_s_tready", 32'(s_axis_tready), 32'(0));
        @(posedge clk);
        #2 resetn = 1'b1;
        @(posedge clk);
        #1;
        check("tready_after_release", 32'(s_axis_tready), 32'(1));

        // Basic crop, full throughput
        b0 = out_beats; e0 = err_pulses;
        send_frame(8, 4, 2, 1, 3, 2, 1'b1, -1, 1'b0, 10);
        drain();
        check("basic_beats", 32'(out_beats - b0), 32'(6));
        check("basic_err",   32'(err_pulses - e0), 32'(0));

        // Same crop with a 1010 output stall pattern
        b0 = out_beats; e0 = err_pulses;
        tog_en = 1'b1;
        fork
            while (tog_en) begin
                @(posedge clk);
                #1;
                if (tog_en) m_axis_tready = ~m_axis_tready;
            end
        join_none
        send_frame(8, 4, 2, 1, 3, 2, 1'b1, -1, 1'b0, 10);
        drain();
        tog_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 m_axis_tready = 1'b1;
        check("stall_beats", 32'(out_beats - b0), 32'(6));
        check("stall_err",   32'(err_pulses - e0), 32'(0));

        // Invalid windows: zero width, then x overflow past 2^12
        b0 = out_beats; e0 = err_pulses;
        send_frame(8, 4, 2, 1, 0, 2, 1'b0, -1, 1'b0, 20);
        repeat (3) @(posedge clk);
        #1;
        check("zero_width_err",   32'(err_pulses - e0), 32'(1));
        check("zero_width_beats", 32'(out_beats - b0), 32'(0));
        e0 = err_pulses;
        send_frame(8, 4, 4090, 1, 10, 2, 1'b0, -1, 1'b0, 25);
        repeat (3) @(posedge clk);
        #1;
        check("overflow_err",   32'(err_pulses - e0), 32'(1));
        check("overflow_beats", 32'(out_beats - b0), 32'(0));
        e0 = err_pulses;
        send_frame(8, 4, 1, 2, 4, 2, 1'b1, -1, 1'b0, 30);
        drain();
        check("recover_beats", 32'(out_beats - b0), 32'(8));
        check("recover_err",   32'(err_pulses - e0), 32'(0));

        // Truncated frame: new SOF at row 1, col 3
        b0 = out_beats; e0 = err_pulses;
        send_frame(8, 4, 0, 0, 8, 4, 1'b1, 11, 1'b0, 40);
        send_frame(8, 4, 0, 0, 8, 4, 1'b1, -1, 1'b0, 50);
        drain();
        check("trunc_err",   32'(err_pulses - e0), 32'(1));
        check("trunc_beats", 32'(out_beats - b0), 32'(43));

        // Window ports scrambled mid-frame
        b0 = out_beats; e0 = err_pulses;
        send_frame(8, 4, 1, 0, 2, 3, 1'b1, -1, 1'b1, 60);
        send_frame(8, 4, 5, 2, 3, 2, 1'b1, -1, 1'b0, 70);
        drain();
        check("midchg_beats", 32'(out_beats - b0), 32'(12));
        check("midchg_err",   32'(err_pulses - e0), 32'(0));

        // Reset with two beats buffered
        m_axis_tready = 1'b0;
        send_frame(8, 4, 0, 0, 8, 4, 1'b1, 2, 1'b0, 80);
        @(negedge clk);
        check("full_tready", 32'(s_axis_tready), 32'(0));
        check("full_tvalid", 32'(m_axis_tvalid), 32'(1));
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("midrst_m_tvalid", 32'(m_axis_tvalid), 32'(0));
        check("midrst_m_tdata",  32'(m_axis_tdata),  32'(0));
        check("midrst_m_tuser",  32'(m_axis_tuser),  32'(0));
        check("midrst_m_tlast",  32'(m_axis_tlast),  32'(0));
        check("midrst_err",      32'(o_frame_err),   32'(0));
        check("midrst_s_tready", 32'(s_axis_tready), 32'(0));
        exp_q.delete();
        m_axis_tready = 1'b1;
        @(posedge clk);
        #2 resetn = 1'b1;
        @(posedge clk);
        #1;
        b0 = out_beats; e0 = err_pulses;
        for (int c = 2; c < 8; c++)
            send_beat(PW'(90 + c), 1'b0, (c == 7), 1'b0, '0);
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_no_stale", 32'(out_beats - b0), 32'(0));
        send_frame(8, 4, 0, 0, 8, 4, 1'b1, -1, 1'b0, 100);
        drain();
        check("post_rst_beats", 32'(out_beats - b0), 32'(32));
        check("post_rst_err",   32'(err_pulses - e0), 32'(0));

        print_summary();
        $finish;
    end

endmodule
